// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: byte width and sequencer state encodings.
package uart_tx_queue_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_txq_mem.sv
// Simple dual-port byte RAM: synchronous write port, asynchronous read port.
module uart_txq_mem
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned DATA_W     = UART_DATA_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus send/done handshake sequencer feeding uart_tx on the bit clock.
// Optional sticky overflow output enabled by defining UART_TXQ_OVERFLOW_EN.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned DATA_W     = UART_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [DATA_W-1:0]   din,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                tx_send,
  output logic [DATA_W-1:0]   tx_data,
  input  logic                tx_done,
`ifdef UART_TXQ_OVERFLOW_EN
  output logic                overflow,
`endif
  output logic                busy
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_n;
  logic [PW-1:0]     rd_ptr_n;
  logic [PW-1:0]     count_n;
  logic              push;
  logic              pop;
  logic              active_n;
  logic [DATA_W-1:0] rd_data;
  txq_state_e        state;

  // Full is the pre-edge flag, so a write while full is dropped even if a pop happens too.
  always_comb begin
    push     = wr && !full;
    pop      = (state == ST_IDLE) && !empty && !tx_done;
    wr_ptr_n = wr_ptr + PW'(push);
    rd_ptr_n = rd_ptr + PW'(pop);
    count_n  = wr_ptr_n - rd_ptr_n;
    active_n = pop || (state == ST_SEND) || ((state == ST_RELEASE) && tx_done);
  end

  uart_txq_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (din),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rd_data)
  );

  // Pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      busy   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == PW'(DEPTH));
      empty  <= (count_n == '0);
      busy   <= active_n || (count_n != '0);
    end
  end

  // Sequencer; IDLE waits for done low so a frame still running after reset is respected.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data <= rd_data;
            tx_send <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            tx_send <= 1'b0;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_send <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXQ_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a scoreboard of expected bytes
// and a bench-driven stand-in for uart_tx's done handshake.
module tb_uart_tx_queue;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
`ifdef UART_TXQ_OVERFLOW_EN
  logic       overflow;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  uart_tx_queue #(
    .DEPTH_LOG2 (3),
    .DATA_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .din      (din),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
`ifdef UART_TXQ_OVERFLOW_EN
    .overflow (overflow),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in for uart_tx: accept one byte, raise done 5 clk later for 3 clk.
  task automatic serve();
    int waited;
    logic [7:0] exp;
    waited = 0;
    while (tx_send !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("send_seen", 16'(tx_send), 16'h1);
    if (tx_send !== 1'b1) return;
    if (sb.size() == 0) begin
      check("sb_underflow", 16'(sb.size()), 16'h1);
      exp = 8'h00;
    end else begin
      exp = sb.pop_front();
    end
    check("tx_data", 16'(tx_data), 16'(exp));
    repeat (4) tick();
    check("send_hold", 16'(tx_send), 16'h1);
    check("data_hold", 16'(tx_data), 16'(exp));
    tx_done = 1'b1;
    tick();
    check("send_fall", 16'(tx_send), 16'h0);
    repeat (2) begin
      tick();
      check("no_send_done_hi", 16'(tx_send), 16'h0);
    end
    tx_done = 1'b0;
    tick();
    check("no_send_release", 16'(tx_send), 16'h0);
    if (sb.size() > 0) begin
      tick();
      check("resend", 16'(tx_send), 16'h1);
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    din     = 8'h00;
    tx_done = 1'b0;

    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_empty", 16'(empty), 16'h1);
      check("rst_full", 16'(full), 16'h0);
      check("rst_count", 16'(count), 16'h0);
      check("rst_send", 16'(tx_send), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
    end
    check("rst_data", 16'(tx_data), 16'h00);

    // Ordered burst of four bytes, first-byte latency of two edges
    wr = 1'b1; din = 8'hA9; sb.push_back(din);
    tick();
    check("lat_edge1_send", 16'(tx_send), 16'h0);
    check("lat_edge1_count", 16'(count), 16'h1);
    check("lat_edge1_busy", 16'(busy), 16'h1);
    din = 8'h99; sb.push_back(din);
    tick();
    check("lat_edge2_send", 16'(tx_send), 16'h1);
    din = 8'hB1; sb.push_back(din);
    tick();
    din = 8'hEA; sb.push_back(din);
    tick();
    wr = 1'b0;
    check("burst_count", 16'(count), 16'h3);
    for (int i = 0; i < 4; i++) serve();
    check("burst_empty", 16'(empty), 16'h1);
    check("burst_count0", 16'(count), 16'h0);
    check("burst_busy", 16'(busy), 16'h0);

    // Simultaneous write and pop at count=3
    tx_done = 1'b1;
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'hC0 + 8'(i);
      sb.push_back(din);
      tick();
    end
    wr = 1'b0;
    check("sim_pre_count", 16'(count), 16'h3);
    check("sim_pre_send", 16'(tx_send), 16'h0);
    tx_done = 1'b0;
    wr = 1'b1; din = 8'hC3; sb.push_back(din);
    tick();
    wr = 1'b0;
    check("sim_count", 16'(count), 16'h3);
    check("sim_full", 16'(full), 16'h0);
    check("sim_send", 16'(tx_send), 16'h1);
    for (int i = 0; i < 4; i++) serve();

    // Fill to full with done stuck low; tenth byte is dropped
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1;
      din = 8'(i);
      if (i < 9) sb.push_back(din);
      tick();
      if (i == 7) begin
        check("fill_count7", 16'(count), 16'h7);
        check("fill_notfull", 16'(full), 16'h0);
      end
      if (i == 8) begin
        check("fill_count8", 16'(count), 16'h8);
        check("fill_full", 16'(full), 16'h1);
`ifdef UART_TXQ_OVERFLOW_EN
        check("ovf_clear", 16'(overflow), 16'h0);
`endif
      end
      if (i == 9) begin
        check("drop_count", 16'(count), 16'h8);
        check("drop_full", 16'(full), 16'h1);
`ifdef UART_TXQ_OVERFLOW_EN
        check("ovf_set", 16'(overflow), 16'h1);
`endif
      end
    end
    wr = 1'b0;
    check("fill_head", 16'(tx_data), 16'h00);
    for (int i = 0; i < 9; i++) serve();
    check("drain_empty", 16'(empty), 16'h1);

    // Reset mid-frame with five queued bytes
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 8'hD0 + 8'(i);
      tick();
    end
    wr = 1'b0;
    check("mid_count5", 16'(count), 16'h5);
    check("mid_send", 16'(tx_send), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("mid_rst_count", 16'(count), 16'h0);
    check("mid_rst_send", 16'(tx_send), 16'h0);
    check("mid_rst_empty", 16'(empty), 16'h1);
    check("mid_rst_busy", 16'(busy), 16'h0);
`ifdef UART_TXQ_OVERFLOW_EN
    check("mid_rst_ovf", 16'(overflow), 16'h0);
`endif
    tx_done = 1'b1;
    wr = 1'b1; din = 8'hE0; sb.push_back(din);
    tick();
    wr = 1'b0;
    check("post_rst_count", 16'(count), 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_hold", 16'(tx_send), 16'h0);
    end
    tx_done = 1'b0;
    tick();
    check("post_rst_send", 16'(tx_send), 16'h1);
    serve();
    check("final_empty", 16'(empty), 16'h1);
    check("final_sb", 16'(sb.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
